// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - Fetch stage: PC, single-outstanding instruction reads, prefetch FIFO to decode
`ifndef InstructionWidth
`define InstructionWidth 32
`endif

module instruction_fetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    output logic                         mem_req,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    input  logic                         mem_ready,
    input  logic                         mem_rvalid,
    input  logic [`InstructionWidth-1:0] mem_rdata,
    input  logic                         in_Branch,
    input  logic [ADDR_WIDTH-1:0]        in_Branch_target,
    output logic [`InstructionWidth-1:0] out_Instruction,
    output logic [ADDR_WIDTH-1:0]        out_Pc,
    output logic                         out_Valid,
    input  logic                         in_Ready
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t                       r_state;
    logic [ADDR_WIDTH-1:0]        r_pc;
    logic [ADDR_WIDTH-1:0]        r_req_pc;
    logic [`InstructionWidth-1:0] r_instr [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]        r_pcbuf [FIFO_DEPTH];
    logic [PTR_W-1:0]             r_rd_ptr;
    logic [PTR_W-1:0]             r_wr_ptr;
    logic [CNT_W-1:0]             r_count;

    state_t                       w_next_state;
    logic [ADDR_WIDTH-1:0]        w_next_pc;
    logic [ADDR_WIDTH-1:0]        w_branch_pc;
    logic                         w_accept;
    logic                         w_push;
    logic                         w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_branch_pc = {in_Branch_target[ADDR_WIDTH-1:2], 2'b00};
    assign mem_addr    = r_pc;
    assign out_Valid   = (r_count != '0);
    assign w_pop       = out_Valid && in_Ready && !in_Branch;

    // Empty FIFO presents zeros rather than stale storage.
    assign out_Instruction = out_Valid ? r_instr[r_rd_ptr] : '0;
    assign out_Pc          = out_Valid ? r_pcbuf[r_rd_ptr] : '0;

    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_push       = 1'b0;
        w_accept     = 1'b0;
        mem_req      = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req  = !reset && (r_count < DEPTH_C);
                w_accept = mem_req && mem_ready;
                if (w_accept) begin
                    w_next_state = in_Branch ? S_DROP : S_WAIT;
                    w_next_pc    = r_pc + ADDR_WIDTH'(4);
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    w_next_state = S_FETCH;
                    w_push       = !in_Branch;
                end else if (in_Branch) begin
                    w_next_state = S_DROP;
                end
            end
            S_DROP: begin
                if (mem_rvalid) begin
                    w_next_state = S_FETCH;
                end
            end
            default: w_next_state = S_FETCH;
        endcase
        // A redirect always owns the PC, whatever the state did above.
        if (in_Branch) begin
            w_next_pc = w_branch_pc;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_FETCH;
            r_pc     <= RESET_PC;
            r_req_pc <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
            if (w_accept) begin
                r_req_pc <= r_pc;
            end
            if (in_Branch) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= ptr_inc(r_wr_ptr);
                end
                if (w_pop) begin
                    r_rd_ptr <= ptr_inc(r_rd_ptr);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_instr[r_wr_ptr] <= mem_rdata;
            r_pcbuf[r_wr_ptr] <= r_req_pc;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - Scoreboard bench for instruction_fetch with a latency-randomised memory model
`ifndef InstructionWidth
`define InstructionWidth 32
`endif

module tb_instruction_fetch;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready = 1'b1;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        in_Branch = 1'b0;
    logic [31:0] in_Branch_target = '0;
    logic [31:0] out_Instruction;
    logic [31:0] out_Pc;
    logic        out_Valid;
    logic        in_Ready = 1'b1;

    instruction_fetch #(.ADDR_WIDTH(32), .RESET_PC(RPC), .FIFO_DEPTH(2)) dut (
        .clock(clock), .reset(reset),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .in_Branch(in_Branch), .in_Branch_target(in_Branch_target),
        .out_Instruction(out_Instruction), .out_Pc(out_Pc),
        .out_Valid(out_Valid), .in_Ready(in_Ready)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
    endfunction

    // Reference model: the program stream is sequential words from the last reset or redirect.
    logic [31:0] exp_q[$];
    logic [31:0] gen_pc;

    task automatic model_fill();
        while (exp_q.size() < 16) begin
            exp_q.push_back(gen_pc);
            gen_pc = gen_pc + 32'd4;
        end
    endtask

    task automatic model_restart(input logic [31:0] pc);
        exp_q.delete();
        gen_pc = {pc[31:2], 2'b00};
        model_fill();
    endtask

    // Memory model: one outstanding read, latency 1..max_lat cycles after accept.
    int unsigned max_lat = 1;
    bit          rand_ready = 1'b0;
    bit          force_stall = 1'b0;
    bit          acc_seen = 1'b0;
    logic [31:0] acc_addr = '0;
    logic [31:0] acc_log[$];
    bit          busy = 1'b0;
    int          remain = 0;
    logic [31:0] busy_addr = '0;

    always @(negedge clock) begin
        acc_seen = mem_req && mem_ready;
        if (acc_seen) begin
            acc_addr = mem_addr;
            acc_log.push_back(mem_addr);
        end
    end

    always begin
        @(posedge clock);
        #1;
        mem_rvalid = 1'b0;
        if (reset) begin
            busy = 1'b0;
        end else begin
            if (acc_seen) begin
                busy      = 1'b1;
                busy_addr = acc_addr;
                remain    = int'($urandom_range(max_lat, 1));
            end
            if (busy) begin
                remain = remain - 1;
                if (remain == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = word_of(busy_addr);
                    busy       = 1'b0;
                end
            end
        end
        mem_ready = force_stall ? 1'b0 : (rand_ready ? ($urandom_range(3, 0) != 0) : 1'b1);
    end

    // Monitor: pops the scoreboard on every consumed head, plus per-cycle hold/idle rules.
    logic [31:0] pop_log[$];
    bit          prev_stall = 1'b0;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_hpc = '0;
    logic [31:0] prev_hins = '0;

    always @(negedge clock) begin : mon
        logic [31:0] e;
        if (!reset) begin
            if (prev_stall) begin
                check("req_held", 32'(mem_req), 32'd1);
                check("addr_held", mem_addr, prev_addr);
            end
            if (prev_hold) begin
                check("head_pc_held", out_Pc, prev_hpc);
                check("head_ins_held", out_Instruction, prev_hins);
            end
            if (mem_req) begin
                check("addr_align", 32'(mem_addr[1:0]), 32'd0);
            end
            if (!out_Valid) begin
                check("empty_pc_zero", out_Pc, 32'd0);
                check("empty_ins_zero", out_Instruction, 32'd0);
            end
            if (out_Valid && in_Ready && !in_Branch) begin
                pop_log.push_back(out_Pc);
                if (exp_q.size() == 0) begin
                    check("sb_nonempty", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_pc", out_Pc, e);
                    check("pop_ins", out_Instruction, word_of(e));
                    model_fill();
                end
            end
            prev_stall = mem_req && !mem_ready && !in_Branch;
            prev_addr  = mem_addr;
            prev_hold  = out_Valid && !in_Ready && !in_Branch;
            prev_hpc   = out_Pc;
            prev_hins  = out_Instruction;
        end else begin
            prev_stall = 1'b0;
            prev_hold  = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        in_Branch = 1'b0;
        @(posedge clock);
        #2;
        reset = 1'b1;
        model_restart(RPC);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_acc_from(input int start, input string name, output logic [31:0] addr);
        int n = 0;
        while (acc_log.size() <= start && n < 200) begin
            @(posedge clock);
            #2;
            n++;
        end
        check({name, "_seen"}, 32'(acc_log.size() > start), 32'd1);
        addr = (acc_log.size() > start) ? acc_log[start] : 32'hDEAD_BEEF;
    endtask

    task automatic wait_pop_from(input int start, input string name, output logic [31:0] pc);
        int n = 0;
        while (pop_log.size() <= start && n < 200) begin
            @(posedge clock);
            #2;
            n++;
        end
        check({name, "_seen"}, 32'(pop_log.size() > start), 32'd1);
        pc = (pop_log.size() > start) ? pop_log[start] : 32'hDEAD_BEEF;
    endtask

    task automatic wait_acc_addr(input logic [31:0] want, input string name);
        logic [31:0] a = '0;
        for (int n = 0; n < 20; n++) begin
            wait_acc_from(acc_log.size(), name, a);
            if (a == want) break;
        end
        check(name, a, want);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] a;
        int s;
        int ps;
        int p0;

        // Reset values and first request address
        #2;
        reset = 1'b1;
        model_restart(RPC);
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_out_valid", 32'(out_Valid), 32'd0);
        check("rst_out_ins", out_Instruction, 32'd0);
        check("rst_out_pc", out_Pc, 32'd0);
        s = acc_log.size();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_addr", mem_addr, RPC);
        check("post_rst_req", 32'(mem_req), 32'd1);

        // Streaming: sequential addresses, one instruction per two cycles
        wait_acc_from(s, "acc0", a);     check("acc0_addr", a, 32'h0);
        wait_acc_from(s + 1, "acc1", a); check("acc1_addr", a, 32'h4);
        wait_acc_from(s + 2, "acc2", a); check("acc2_addr", a, 32'h8);
        wait_acc_from(s + 3, "acc3", a); check("acc3_addr", a, 32'hC);
        wait_pop_from(pop_log.size(), "tp_sync", a);
        p0 = pop_log.size();
        repeat (20) @(posedge clock);
        #2;
        check("throughput_20cyc", 32'(pop_log.size() - p0), 32'd10);

        // Backpressure: FIFO fills to two entries, then fetch resumes at 8
        in_Ready = 1'b0;
        do_reset();
        repeat (10) tick();
        check("bp_valid", 32'(out_Valid), 32'd1);
        check("bp_head_pc", out_Pc, 32'h0);
        check("bp_req_off", 32'(mem_req), 32'd0);
        s = acc_log.size();
        ps = pop_log.size();
        in_Ready = 1'b1;
        wait_pop_from(ps, "bp_pop0", a);     check("bp_pop0_pc", a, 32'h0);
        wait_pop_from(ps + 1, "bp_pop1", a); check("bp_pop1_pc", a, 32'h4);
        wait_acc_from(s, "bp_resume", a);    check("bp_resume_addr", a, 32'h8);

        // Redirect while waiting on address 8
        max_lat = 3;
        do_reset();
        wait_acc_addr(32'h8, "br_wait_acc8");
        s = acc_log.size();
        ps = pop_log.size();
        in_Branch = 1'b1;
        in_Branch_target = 32'h0000_0102;
        model_restart(32'h0000_0102);
        tick();
        in_Branch = 1'b0;
        wait_acc_from(s, "br_acc", a);  check("br_next_addr", a, 32'h100);
        wait_pop_from(ps, "br_pop", a); check("br_next_pc", a, 32'h100);

        // Redirect on the same cycle as a pop with a full FIFO
        max_lat = 1;
        in_Ready = 1'b0;
        do_reset();
        repeat (10) tick();
        check("full_valid", 32'(out_Valid), 32'd1);
        ps = pop_log.size();
        in_Ready = 1'b1;
        in_Branch = 1'b1;
        in_Branch_target = 32'h0000_0200;
        model_restart(32'h0000_0200);
        tick();
        in_Branch = 1'b0;
        check("flush_valid", 32'(out_Valid), 32'd0);
        wait_pop_from(ps, "flush_pop", a); check("flush_first_pc", a, 32'h200);

        // Memory stall: address held, redirect during stall applies without a drop
        force_stall = 1'b1;
        repeat (6) tick();
        a = mem_addr;
        for (int i = 0; i < 5; i++) begin
            check("stall_req", 32'(mem_req), 32'd1);
            check("stall_addr", mem_addr, a);
            tick();
        end
        in_Branch = 1'b1;
        in_Branch_target = 32'h0000_0303;
        model_restart(32'h0000_0303);
        tick();
        in_Branch = 1'b0;
        check("stall_br_addr", mem_addr, 32'h300);
        check("stall_br_req", 32'(mem_req), 32'd1);
        s = acc_log.size();
        ps = pop_log.size();
        force_stall = 1'b0;
        wait_acc_from(s, "stall_acc", a);  check("stall_acc_addr", a, 32'h300);
        wait_pop_from(ps, "stall_pop", a); check("stall_pop_pc", a, 32'h300);

        // Reset asserted while waiting with one entry buffered
        max_lat = 3;
        in_Ready = 1'b0;
        do_reset();
        wait_acc_addr(32'h4, "mid_acc4");
        check("mid_pre_valid", 32'(out_Valid), 32'd1);
        check("mid_pre_pc", out_Pc, 32'h0);
        #1;
        reset = 1'b1;
        model_restart(RPC);
        #1;
        check("mid_rst_valid", 32'(out_Valid), 32'd0);
        check("mid_rst_req", 32'(mem_req), 32'd0);
        check("mid_rst_pc", out_Pc, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        in_Ready = 1'b1;
        @(negedge clock);
        check("mid_post_addr", mem_addr, RPC);
        check("mid_post_req", 32'(mem_req), 32'd1);

        // Randomised traffic with redirects, including wrap-around targets
        max_lat = 4;
        rand_ready = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            tick();
            in_Ready = ($urandom_range(3, 0) != 0);
            if ($urandom_range(15, 0) == 0) begin
                in_Branch = 1'b1;
                in_Branch_target = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF4 | 32'($urandom_range(3, 0)))
                                                               : $urandom;
                model_restart(in_Branch_target);
            end else begin
                in_Branch = 1'b0;
            end
        end
        tick();
        in_Branch = 1'b0;
        in_Ready = 1'b1;
        rand_ready = 1'b0;
        repeat (30) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
